// File: rtl/imem_loader_if.sv
// imem_loader_if: master drives in_valid/in_data/fetch_addr; slave (loader) drives in_ready/fetch_data
interface imem_loader_if #(parameter int AW = 4);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [AW-1:0] fetch_addr;
  logic [7:0]    fetch_data;
  modport master (output in_valid, in_data, fetch_addr, input in_ready, fetch_data);
  modport slave (input in_valid, in_data, fetch_addr, output in_ready, fetch_data);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: framed program loader into a DEPTH x 8 store; ports clk, rst_n, bus (stream+fetch), cpu_run_o, load_done_o, load_error_o, words_loaded_o
module imem_loader #(
  parameter int          DEPTH = 16,
  parameter int          AW    = 4,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.slave  bus,
  output logic          cpu_run_o,
  output logic          load_done_o,
  output logic          load_error_o,
  output logic [AW:0]   words_loaded_o
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;
  localparam logic [7:0] MAXLEN = 8'(DEPTH);
  logic [2:0]  state_q, state_d;
  logic [AW:0] len_q, len_d, cnt_q, cnt_d;
  logic [7:0]  chk_q, chk_d;
  logic        run_q, run_d, done_q, done_d, err_q, err_d;
  logic [7:0]  mem_q [DEPTH];
  logic        acc, bad_len, good_chk;
  assign acc      = bus.in_valid && bus.in_ready;
  assign bad_len  = bus.in_data == 8'd0 || bus.in_data > MAXLEN;
  assign good_chk = bus.in_data == chk_q;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    run_d   = run_q;
    done_d  = done_q;
    err_d   = err_q;
    if (acc)
      case (state_q)
        S_LEN: begin
          state_d = bad_len ? S_ERR : S_DATA;
          err_d   = bad_len;
          len_d   = bus.in_data[AW:0];
          chk_d   = bus.in_data;
        end
        S_DATA: begin
          cnt_d   = cnt_q + 1'b1;
          chk_d   = chk_q ^ bus.in_data;
          state_d = cnt_d == len_q ? S_CHK : S_DATA;
        end
        S_CHK: begin
          state_d = good_chk ? S_DONE : S_ERR;
          run_d   = good_chk;
          done_d  = good_chk;
          err_d   = !good_chk;
        end
        default:
          if (bus.in_data == SYNC) begin
            state_d = S_LEN;
            run_d   = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            cnt_d   = '0;
            chk_d   = '0;
          end
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      chk_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      run_q   <= run_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (acc && state_q == S_DATA) mem_q[cnt_q[AW-1:0]] <= bus.in_data;
    end
  assign bus.in_ready   = 1'b1;
  assign bus.fetch_data = mem_q[bus.fetch_addr];
  assign cpu_run_o      = run_q;
  assign load_done_o    = done_q;
  assign load_error_o   = err_q;
  assign words_loaded_o = cnt_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench; driver queues expected status/fetch results, monitor pops and compares
module tb_imem_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run, done, err;
  logic [4:0] words;
  logic       probe = 1'b0;
  logic       acc_seen = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] sq [$];
  logic [7:0] fq [$];
  imem_loader_if #(.AW(4)) bus ();
  imem_loader dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .cpu_run_o(run),
    .load_done_o(done),
    .load_error_o(err),
    .words_loaded_o(words)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] st(input bit r, input bit d, input bit e, input int w);
    return {r, d, e, 5'(w)};
  endfunction
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  always @(posedge clk) acc_seen <= bus.in_valid && bus.in_ready;
  always @(negedge clk) begin
    if (acc_seen) begin
      if (sq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL status: byte accepted with no expectation queued");
      end else chk("status{run,done,err,words}", {run, done, err, words}, sq.pop_front());
    end
    if (probe) begin
      if (fq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL fetch: probe with no expectation queued");
      end else chk($sformatf("fetch[%0d]", bus.fetch_addr), bus.fetch_data, fq.pop_front());
    end
  end
  task automatic send(input logic [7:0] b, input logic [7:0] exp);
    @(posedge clk);
    #1;
    probe = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = b;
    sq.push_back(exp);
  endtask
  task automatic idle();
    @(posedge clk);
    #1;
    probe = 1'b0;
    bus.in_valid = 1'b0;
  endtask
  task automatic fetch(input logic [3:0] a, input logic [7:0] exp);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.fetch_addr = a;
    probe = 1'b1;
    fq.push_back(exp);
  endtask
  task automatic good_frame();
    send(8'hA5, st(0, 0, 0, 0));
    send(8'h04, st(0, 0, 0, 0));
    send(8'h08, st(0, 0, 0, 1));
    idle();
    send(8'h19, st(0, 0, 0, 2));
    send(8'h2A, st(0, 0, 0, 3));
    idle();
    idle();
    send(8'h3B, st(0, 0, 0, 4));
    send(8'h04, st(1, 1, 0, 4));
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.fetch_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_status", {run, done, err, words}, 8'h00);
    chk("reset_ready", 8'(bus.in_ready), 8'h01);
    rst_n = 1'b1;
    fetch(4'd0, 8'h00);
    fetch(4'd15, 8'h00);
    good_frame();
    fetch(4'd0, 8'h08);
    fetch(4'd1, 8'h19);
    fetch(4'd2, 8'h2A);
    fetch(4'd3, 8'h3B);
    fetch(4'd4, 8'h00);
    send(8'hA5, st(0, 0, 0, 0));
    send(8'h04, st(0, 0, 0, 0));
    send(8'h08, st(0, 0, 0, 1));
    send(8'h19, st(0, 0, 0, 2));
    send(8'h2A, st(0, 0, 0, 3));
    send(8'h3B, st(0, 0, 0, 4));
    send(8'h05, st(0, 0, 1, 4));
    fetch(4'd0, 8'h08);
    fetch(4'd3, 8'h3B);
    send(8'hA5, st(0, 0, 0, 0));
    send(8'h00, st(0, 0, 1, 0));
    send(8'hA5, st(0, 0, 0, 0));
    send(8'h11, st(0, 0, 1, 0));
    send(8'h3C, st(0, 0, 1, 0));
    fetch(4'd0, 8'h08);
    fetch(4'd1, 8'h19);
    good_frame();
    send(8'hA5, st(0, 0, 0, 0));
    send(8'h01, st(0, 0, 0, 0));
    send(8'hFF, st(0, 0, 0, 1));
    send(8'hFE, st(1, 1, 0, 1));
    fetch(4'd0, 8'hFF);
    fetch(4'd1, 8'h19);
    fetch(4'd2, 8'h2A);
    fetch(4'd3, 8'h3B);
    send(8'h00, st(1, 1, 0, 1));
    send(8'h77, st(1, 1, 0, 1));
    send(8'hA5, st(0, 0, 0, 0));
    send(8'h02, st(0, 0, 0, 0));
    send(8'hA5, st(0, 0, 0, 1));
    send(8'hA5, st(0, 0, 0, 2));
    send(8'h02, st(1, 1, 0, 2));
    fetch(4'd0, 8'hA5);
    fetch(4'd1, 8'hA5);
    fetch(4'd2, 8'h2A);
    send(8'hA5, st(0, 0, 0, 0));
    send(8'h04, st(0, 0, 0, 0));
    send(8'h11, st(0, 0, 0, 1));
    send(8'h22, st(0, 0, 0, 2));
    idle();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_status", {run, done, err, words}, 8'h00);
    chk("midreset_ready", 8'(bus.in_ready), 8'h01);
    for (int a = 0; a < 4; a++) fetch(4'(a), 8'h00);
    fetch(4'd15, 8'h00);
    idle();
    rst_n = 1'b1;
    send(8'h01, st(0, 0, 0, 0));
    send(8'hA5, st(0, 0, 0, 0));
    send(8'h01, st(0, 0, 0, 0));
    send(8'h5A, st(0, 0, 0, 1));
    send(8'h5B, st(1, 1, 0, 1));
    fetch(4'd0, 8'h5A);
    fetch(4'd1, 8'h00);
    idle();
    repeat (3) @(posedge clk);
    n_chk++;
    if (sq.size() != 0 || fq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d status and %0d fetch expectations left, required 0", sq.size(), fq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
